// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0 prefix sequences into single key
// events, filters typematic repeats and maps game keys onto 3-bit commands.

module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter bit FILTER_REPEAT  = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_ready,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       err_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] CMD_NONE     = 3'd0;
    localparam logic [2:0] CMD_RIGHT    = 3'd1;
    localparam logic [2:0] CMD_LEFT     = 3'd2;
    localparam logic [2:0] CMD_DOWN     = 3'd3;
    localparam logic [2:0] CMD_UP       = 3'd4;
    localparam logic [2:0] CMD_PLACE_X  = 3'd5;
    localparam logic [2:0] CMD_PLACE_O  = 3'd6;
    localparam logic [2:0] CMD_NEW_GAME = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          armed_q;

    logic          held_valid_q;
    logic          held_ext_q;
    logic [7:0]    held_code_q;

    logic          key_valid_q;
    logic [7:0]    key_code_q;
    logic          key_ext_q;
    logic          key_release_q;
    logic          cmd_valid_q;
    logic [2:0]    cmd_q;
    logic          err_timeout_q;

    logic          is_e0;
    logic          is_f0;
    logic          is_e1;
    logic          is_noise;
    logic          in_ext;
    logic          in_brk;
    logic          final_byte;
    logic          held_match;
    logic [2:0]    map_cmd;

    always_comb begin
        is_e0 = (scan_code == 8'hE0);
        is_f0 = (scan_code == 8'hF0);
        is_e1 = (scan_code == 8'hE1);

        // Keyboard housekeeping bytes (BAT, ACK, errors) only matter between keys.
        case (scan_code)
            8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_noise = 1'b1;
            default:                                 is_noise = 1'b0;
        endcase

        in_ext     = (state_q == EXT) || (state_q == EXT_BRK);
        in_brk     = (state_q == BRK) || (state_q == EXT_BRK);
        final_byte = !is_e0 && !is_f0 && !is_e1 && !((state_q == IDLE) && is_noise);
        held_match = held_valid_q && (held_ext_q == in_ext) && (held_code_q == scan_code);

        map_cmd = CMD_NONE;
        if (in_ext) begin
            case (scan_code)
                8'h74:   map_cmd = CMD_RIGHT;
                8'h6B:   map_cmd = CMD_LEFT;
                8'h72:   map_cmd = CMD_DOWN;
                8'h75:   map_cmd = CMD_UP;
                default: map_cmd = CMD_NONE;
            endcase
        end else begin
            case (scan_code)
                8'h29:   map_cmd = CMD_PLACE_X;
                8'h5A:   map_cmd = CMD_PLACE_O;
                8'h2D:   map_cmd = CMD_NEW_GAME;
                default: map_cmd = CMD_NONE;
            endcase
        end
    end

    // armed_q blanks the first edge after reset release so a byte arriving
    // alongside the deassertion is dropped.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            held_valid_q  <= 1'b0;
            held_ext_q    <= 1'b0;
            held_code_q   <= 8'h00;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= CMD_NONE;
            err_timeout_q <= 1'b0;
        end else begin
            armed_q       <= 1'b1;
            key_valid_q   <= 1'b0;
            cmd_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;

            if (scan_ready && armed_q) begin
                cnt_q <= '0;
                if (!is_e1) begin
                    if (is_e0) begin
                        state_q <= EXT;
                    end else if (is_f0) begin
                        state_q <= in_ext ? EXT_BRK : BRK;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                if (final_byte) begin
                    if (in_brk) begin
                        key_valid_q   <= 1'b1;
                        key_code_q    <= scan_code;
                        key_ext_q     <= in_ext;
                        key_release_q <= 1'b1;
                        cmd_q         <= CMD_NONE;
                        if (held_match) begin
                            held_valid_q <= 1'b0;
                        end
                    end else if (!(FILTER_REPEAT && held_match)) begin
                        key_valid_q   <= 1'b1;
                        key_code_q    <= scan_code;
                        key_ext_q     <= in_ext;
                        key_release_q <= 1'b0;
                        cmd_q         <= map_cmd;
                        cmd_valid_q   <= (map_cmd != CMD_NONE);
                        held_valid_q  <= 1'b1;
                        held_ext_q    <= in_ext;
                        held_code_q   <= scan_code;
                    end
                end
            end else if (state_q != IDLE) begin
                // An incoming byte on the expiry cycle takes the branch above instead.
                if (cnt_q == CNT_LAST) begin
                    state_q       <= IDLE;
                    cnt_q         <= '0;
                    err_timeout_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_release_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd         = cmd_q;
    assign err_timeout = err_timeout_q;

endmodule
